bcd_engine_arbiter: RTL and testbench

- Shares one binary_to_bcd conversion engine among NUM_REQ requesters, e.g. the button counter, display refresh and a debug readout.
- Round-robin arbitration, operand capture, engine start sequencing, result return to the granted requester, and a watchdog if the engine never completes.
- Sits between the requesters and the single binary_to_bcd instance in the top level.

---
 rtl/bcd_engine_arbiter_pkg.sv | 20 ++
 rtl/bcd_engine_arbiter_rr_priority_select.sv | 32 +++
 rtl/bcd_engine_arbiter.sv | 125 ++++++++++++
 tb/tb_bcd_engine_arbiter.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_engine_arbiter_pkg.sv
// Shared definitions for the BCD engine arbiter: FSM encoding, clock
// frequency and a constant-width helper.
package bcd_engine_arbiter_pkg;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_WAIT = 1'b1
   } state_t;

   localparam int SYSCLOCK_FREQ = 100_000_000;

   // Ceiling log2, usable in constant expressions; clog2(1) = 0.
   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r++;
      return r;
   endfunction

endpackage

// File: rtl/bcd_engine_arbiter_rr_priority_select.sv
// Round-robin winner selection: the first set request bit found by searching
// upward circularly from the requester after last_grant.
module rr_priority_select
   import bcd_engine_arbiter_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   last_grant,
   output logic               any,
   output logic [IDX_W-1:0]   grant
);

   // Rotate-and-priority-encode; the index wraps from NUM_REQ-1 back to 0.
   always_comb begin : sel
      int  idx;
      logic found;
      any   = |req;
      grant = '0;
      found = 1'b0;
      for (int i = 1; i <= NUM_REQ; i++) begin
         idx = int'(last_grant) + i;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         if (!found && req[idx]) begin
            grant = IDX_W'(idx);
            found = 1'b1;
         end
      end
   end

endmodule

// File: rtl/bcd_engine_arbiter.sv
// Shares a single binary_to_bcd engine among NUM_REQ requesters: round-robin
// grant, operand capture, start pulse, result return and a watchdog abort.
module bcd_engine_arbiter
   import bcd_engine_arbiter_pkg::*;
#(
   parameter int NUM_REQ        = 4,
   parameter int INPUT_WIDTH    = 16,
   parameter int DECIMAL_DIGITS = 4,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [NUM_REQ-1:0]            req,
   input  logic [NUM_REQ*INPUT_WIDTH-1:0] req_bin,
   output logic [NUM_REQ-1:0]            req_ack,
   output logic [NUM_REQ-1:0]            rsp_valid,
   output logic [4*DECIMAL_DIGITS-1:0]   rsp_bcd,
   output logic                          rsp_error,
   output logic                          busy,
   output logic [INPUT_WIDTH-1:0]        eng_bin,
   output logic                          eng_start,
   input  logic [4*DECIMAL_DIGITS-1:0]   eng_bcd,
   input  logic                          eng_dv
);

   localparam int IDX_W = clog2(NUM_REQ);
   localparam int WD_W  = clog2(TIMEOUT_CYCLES + 1);
   localparam int BCD_W = 4 * DECIMAL_DIGITS;

   state_t                 state, state_nxt;
   logic [IDX_W-1:0]       last_grant, last_grant_nxt;
   logic [WD_W-1:0]        wd, wd_nxt;
   logic [NUM_REQ-1:0]     req_ack_nxt, rsp_valid_nxt;
   logic [BCD_W-1:0]       rsp_bcd_nxt;
   logic                   rsp_error_nxt, busy_nxt, eng_start_nxt;
   logic [INPUT_WIDTH-1:0] eng_bin_nxt;

   logic                   any_req;
   logic [IDX_W-1:0]       grant;

   rr_priority_select #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_sel (
      .req        (req),
      .last_grant (last_grant),
      .any        (any_req),
      .grant      (grant)
   );

   // Next-state and next-output logic; every output is registered below.
   always_comb begin
      state_nxt      = state;
      last_grant_nxt = last_grant;
      wd_nxt         = wd;
      req_ack_nxt    = '0;
      rsp_valid_nxt  = '0;
      eng_start_nxt  = 1'b0;
      rsp_bcd_nxt    = rsp_bcd;
      rsp_error_nxt  = rsp_error;
      busy_nxt       = busy;
      eng_bin_nxt    = eng_bin;
      case (state)
         S_IDLE: begin
            // eng_dv is deliberately not looked at here
            if (any_req) begin
               eng_bin_nxt        = req_bin[int'(grant)*INPUT_WIDTH +: INPUT_WIDTH];
               eng_start_nxt      = 1'b1;
               req_ack_nxt[grant] = 1'b1;
               busy_nxt           = 1'b1;
               last_grant_nxt     = grant;
               wd_nxt             = '0;
               state_nxt          = S_WAIT;
            end
         end
         S_WAIT: begin
            // done is honoured only after the start pulse; it beats the watchdog
            if (eng_dv && !eng_start) begin
               rsp_bcd_nxt               = eng_bcd;
               rsp_valid_nxt[last_grant] = 1'b1;
               rsp_error_nxt             = 1'b0;
               busy_nxt                  = 1'b0;
               state_nxt                 = S_IDLE;
            end else if (wd == WD_W'(TIMEOUT_CYCLES - 1)) begin
               rsp_bcd_nxt               = '0;
               rsp_valid_nxt[last_grant] = 1'b1;
               rsp_error_nxt             = 1'b1;
               busy_nxt                  = 1'b0;
               state_nxt                 = S_IDLE;
            end else begin
               wd_nxt = wd + WD_W'(1);
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         last_grant <= IDX_W'(NUM_REQ - 1);
         wd         <= '0;
         req_ack    <= '0;
         rsp_valid  <= '0;
         rsp_bcd    <= '0;
         rsp_error  <= 1'b0;
         busy       <= 1'b0;
         eng_bin    <= '0;
         eng_start  <= 1'b0;
      end else begin
         state      <= state_nxt;
         last_grant <= last_grant_nxt;
         wd         <= wd_nxt;
         req_ack    <= req_ack_nxt;
         rsp_valid  <= rsp_valid_nxt;
         rsp_bcd    <= rsp_bcd_nxt;
         rsp_error  <= rsp_error_nxt;
         busy       <= busy_nxt;
         eng_bin    <= eng_bin_nxt;
         eng_start  <= eng_start_nxt;
      end
   end

endmodule

// File: tb/tb_bcd_engine_arbiter.sv
// Directed-plus-random bench for bcd_engine_arbiter with a latency-programmable
// engine model and a round-robin reference model.
module tb_bcd_engine_arbiter;

   localparam int NR  = 4;
   localparam int W   = 16;
   localparam int BW  = 16;
   localparam int TMO = 32;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic [NR-1:0]   req = '0;
   logic [NR*W-1:0] req_bin = '0;
   logic [NR-1:0]   req_ack, rsp_valid;
   logic [BW-1:0]   rsp_bcd;
   logic            rsp_error, busy, eng_start;
   logic [W-1:0]    eng_bin;
   logic [BW-1:0]   eng_bcd = '0;
   logic            eng_dv = 1'b0;

   int n_cmp = 0;
   int n_err = 0;
   int cyc = 0;
   int t_start = 0;
   int last_g = NR - 1;
   int eng_lat = 20;
   int eng_cnt = 0;
   logic [W-1:0] eng_op = '0;
   bit spur_dv = 1'b0;
   int ack_cnt [NR];
   int rsp_cnt [NR];

   bcd_engine_arbiter #(
      .NUM_REQ(NR), .INPUT_WIDTH(W), .DECIMAL_DIGITS(4), .TIMEOUT_CYCLES(TMO)
   ) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .req_bin(req_bin),
      .req_ack(req_ack), .rsp_valid(rsp_valid), .rsp_bcd(rsp_bcd),
      .rsp_error(rsp_error), .busy(busy), .eng_bin(eng_bin),
      .eng_start(eng_start), .eng_bcd(eng_bcd), .eng_dv(eng_dv)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] to_bcd(input int v);
      logic [15:0] r;
      r = '0;
      for (int d = 0; d < 4; d++) begin
         r[4*d +: 4] = 4'(v % 10);
         v = v / 10;
      end
      return r;
   endfunction

   function automatic int rr_pick(input int last, input logic [NR-1:0] m);
      for (int k = 1; k <= NR; k++)
         if (m[(last + k) % NR]) return (last + k) % NR;
      return -1;
   endfunction

   // cycle counter
   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // engine model: dv eng_lat cycles after the start pulse; eng_lat = 0 never answers
   initial forever begin
      @(posedge clk);
      #2;
      eng_dv = spur_dv;
      if (eng_cnt > 0) begin
         eng_cnt--;
         if (eng_cnt == 0) begin
            eng_dv  = 1'b1;
            eng_bcd = to_bcd(int'(eng_op));
         end
      end
      if (eng_start && eng_lat > 0) begin
         eng_op  = eng_bin;
         eng_cnt = eng_lat;
      end
   end

   // pulse counters per requester
   initial begin
      for (int i = 0; i < NR; i++) begin ack_cnt[i] = 0; rsp_cnt[i] = 0; end
      forever begin
         @(posedge clk);
         #3;
         for (int i = 0; i < NR; i++) begin
            if (req_ack[i])   ack_cnt[i]++;
            if (rsp_valid[i]) rsp_cnt[i]++;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic set_op(input int i, input logic [W-1:0] v);
      req_bin[i*W +: W] = v;
   endtask

   task automatic expect_grant(input int g, input logic [W-1:0] op, output int waited);
      waited = 0;
      do begin tick(); waited++; end while (req_ack == '0 && waited < 50);
      check("ack", 32'(req_ack), 32'(1 << g));
      check("eng_start", 32'(eng_start), 32'd1);
      check("eng_bin", 32'(eng_bin), 32'(op));
      check("busy_wait", 32'(busy), 32'd1);
      t_start = cyc;
      last_g  = g;
   endtask

   task automatic expect_rsp(input int g, input int dly, input logic [BW-1:0] bcd, input bit err);
      int n;
      n = 0;
      do begin tick(); n++; end while (rsp_valid == '0 && n < 2000);
      check("rsp_delay", 32'(cyc - t_start), 32'(dly));
      check("rsp_valid", 32'(rsp_valid), 32'(1 << g));
      check("rsp_bcd", 32'(rsp_bcd), 32'(bcd));
      check("rsp_error", 32'(rsp_error), 32'(err));
      check("busy_done", 32'(busy), 32'd0);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      last_g = NR - 1;
   endtask

   task automatic check_reset_outputs();
      check("rst_ack", 32'(req_ack), 32'd0);
      check("rst_valid", 32'(rsp_valid), 32'd0);
      check("rst_start", 32'(eng_start), 32'd0);
      check("rst_error", 32'(rsp_error), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_bcd", 32'(rsp_bcd), 32'd0);
      check("rst_bin", 32'(eng_bin), 32'd0);
   endtask

   initial begin
      int g, w, lat, tot;
      logic [W-1:0] op;
      logic [NR-1:0] m;
      logic [W-1:0] ops [NR];

      // reset state
      tick();
      do_reset();
      check_reset_outputs();

      // single request, 20-cycle engine
      eng_lat = 20;
      set_op(0, 16'd1234);
      req = 4'b0001;
      expect_grant(0, 16'd1234, w);
      req = '0;
      expect_rsp(0, 21, 16'h1234, 1'b0);
      tick();
      check("busy_after", 32'(busy), 32'd0);
      check("valid_pulse", 32'(rsp_valid), 32'd0);

      // fairness: all requesting, operands changed after each ack
      do_reset();
      ops[0] = 16'd9; ops[1] = 16'd42; ops[2] = 16'd999; ops[3] = 16'd9999;
      for (int i = 0; i < NR; i++) set_op(i, ops[i]);
      req = '1;
      for (int k = 0; k < 6; k++) begin
         g   = rr_pick(last_g, req);
         op  = req_bin[g*W +: W];
         lat = $urandom_range(1, 20);
         eng_lat = lat;
         expect_grant(g, op, w);
         if (k > 0) check("back_to_back", 32'(w), 32'd1);
         set_op(g, 16'($urandom_range(0, 9999)));
         if (k == 5) req = '0;
         expect_rsp(g, lat + 1, to_bcd(int'(op)), 1'b0);
         if (k == 5) req = '0;
      end
      tick();

      // watchdog expiry, then normal service
      eng_lat = 0;
      m = 4'b0100;
      g = rr_pick(last_g, m);
      op = 16'($urandom_range(0, 9999));
      set_op(g, op);
      req = m;
      expect_grant(g, op, w);
      req = '0;
      expect_rsp(g, TMO, 16'h0000, 1'b1);
      eng_lat = 5;
      m = 4'b1000;
      g = rr_pick(last_g, m);
      op = 16'($urandom_range(0, 9999));
      set_op(g, op);
      req = m;
      expect_grant(g, op, w);
      req = '0;
      expect_rsp(g, 6, to_bcd(int'(op)), 1'b0);

      // dv arriving on the watchdog expiry cycle wins
      eng_lat = TMO - 1;
      m = 4'b0001;
      g = rr_pick(last_g, m);
      op = 16'($urandom_range(0, 9999));
      set_op(g, op);
      req = m;
      expect_grant(g, op, w);
      req = '0;
      expect_rsp(g, TMO, to_bcd(int'(op)), 1'b0);
      tick();

      // spurious dv in idle
      tot = rsp_cnt[0] + rsp_cnt[1] + rsp_cnt[2] + rsp_cnt[3];
      spur_dv = 1'b1;
      tick();
      spur_dv = 1'b0;
      repeat (3) tick();
      check("spurious_rsp", 32'(rsp_cnt[0] + rsp_cnt[1] + rsp_cnt[2] + rsp_cnt[3]), 32'(tot));
      check("spurious_busy", 32'(busy), 32'd0);

      // withdrawal of req[2] while busy
      begin
         int a2, r2;
         a2 = ack_cnt[2];
         r2 = rsp_cnt[2];
         eng_lat = 10;
         m = 4'b0001;
         g = rr_pick(last_g, m);
         op = 16'($urandom_range(0, 9999));
         set_op(g, op);
         req = m;
         expect_grant(g, op, w);
         req = '0;
         repeat (3) tick();
         req = 4'b0100;
         tick();
         req = '0;
         expect_rsp(g, 11, to_bcd(int'(op)), 1'b0);
         repeat (3) tick();
         check("withdraw_ack", 32'(ack_cnt[2]), 32'(a2));
         check("withdraw_rsp", 32'(rsp_cnt[2]), 32'(r2));
      end

      // reset mid-WAIT, late dv ignored, requester 0 first afterwards
      eng_lat = 15;
      m = 4'b0010;
      g = rr_pick(last_g, m);
      op = 16'($urandom_range(0, 9999));
      set_op(g, op);
      req = m;
      expect_grant(g, op, w);
      req = '0;
      repeat (5) tick();
      do_reset();
      check_reset_outputs();
      tot = rsp_cnt[0] + rsp_cnt[1] + rsp_cnt[2] + rsp_cnt[3];
      repeat (15) tick();
      check("late_dv_rsp", 32'(rsp_cnt[0] + rsp_cnt[1] + rsp_cnt[2] + rsp_cnt[3]), 32'(tot));
      check("late_dv_busy", 32'(busy), 32'd0);
      eng_lat = 4;
      for (int i = 0; i < NR; i++) set_op(i, 16'($urandom_range(0, 9999)));
      req = '1;
      g = rr_pick(last_g, req);
      op = req_bin[g*W +: W];
      expect_grant(g, op, w);
      req = '0;
      expect_rsp(g, 5, to_bcd(int'(op)), 1'b0);
      repeat (2) tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
